// File: rtl/axi_rab_pkg.sv
// Shared types and constants for the AXI4 R-channel drop sender.
// Holds the FSM state enum, the SLVERR code and the drop-request entry.
package axi_rab_pkg;

   localparam int unsigned MAX_ID_WIDTH   = 16;
   localparam int unsigned MAX_USER_WIDTH = 16;

   localparam logic [1:0] RRESP_SLVERR = 2'b10;

   typedef enum logic {
      FWD  = 1'b0,
      DROP = 1'b1
   } r_state_t;

   // id/user are sized for the widest supported bus; narrower buses
   // use the low bits only.
   typedef struct packed {
      logic [7:0]                len;
      logic [MAX_ID_WIDTH-1:0]   id;
      logic [MAX_USER_WIDTH-1:0] user;
   } drop_entry_t;

endpackage

// File: rtl/axi4_r_drop_fifo.sv
// Drop-request queue: push/pop with full/empty and first-word head.
// Ports: clk, rst_n, push, pop, din, head, full, empty.
module axi4_r_drop_fifo
   import axi_rab_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  drop_entry_t din,
   output drop_entry_t head,
   output logic        full,
   output logic        empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   // Extra MSB separates full (MSBs differ) from empty (all equal).
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   drop_entry_t mem [DEPTH];

   logic do_push;
   logic do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                  (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign head  = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= din;
   end

endmodule

// File: rtl/axi4_r_sender.sv
// R-channel sender: forwards upstream R beats, or injects SLVERR bursts
// for dropped reads. Ports: drop_* request side, m_axi4_r* in, s_axi4_r* out.
module axi4_r_sender
   import axi_rab_pkg::*;
#(
   parameter int unsigned AXI_DATA_WIDTH  = 32,
   parameter int unsigned AXI_ID_WIDTH    = 4,
   parameter int unsigned AXI_USER_WIDTH  = 4,
   parameter int unsigned DROP_FIFO_DEPTH = 4
) (
   input  logic                      axi4_aclk,
   input  logic                      axi4_arstn,
   input  logic                      drop_i,
   output logic                      drop_ready_o,
   input  logic [7:0]                drop_len_i,
   input  logic [AXI_ID_WIDTH-1:0]   drop_id_i,
   input  logic [AXI_USER_WIDTH-1:0] drop_user_i,
   output logic                      done_o,
   input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
   input  logic [1:0]                m_axi4_rresp,
   input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
   input  logic                      m_axi4_rlast,
   input  logic                      m_axi4_rvalid,
   input  logic [AXI_USER_WIDTH-1:0] m_axi4_ruser,
   output logic                      m_axi4_rready,
   output logic [AXI_ID_WIDTH-1:0]   s_axi4_rid,
   output logic [1:0]                s_axi4_rresp,
   output logic [AXI_DATA_WIDTH-1:0] s_axi4_rdata,
   output logic                      s_axi4_rlast,
   output logic                      s_axi4_rvalid,
   output logic [AXI_USER_WIDTH-1:0] s_axi4_ruser,
   input  logic                      s_axi4_rready
);

   if (AXI_ID_WIDTH > MAX_ID_WIDTH || AXI_USER_WIDTH > MAX_USER_WIDTH) begin : g_chk
      $error("axi4_r_sender: id/user width exceeds package maximum");
   end

   r_state_t    state_q, state_d;
   logic        in_burst_q, in_burst_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        done_d;
   logic        pop;
   logic        fifo_full;
   logic        fifo_empty;
   drop_entry_t push_entry;
   drop_entry_t head;
   logic        last_beat;
   logic        unused_head;

   always_comb begin
      push_entry = '0;
      push_entry.len = drop_len_i;
      push_entry.id[AXI_ID_WIDTH-1:0] = drop_id_i;
      push_entry.user[AXI_USER_WIDTH-1:0] = drop_user_i;
   end

   axi4_r_drop_fifo #(
      .DEPTH (DROP_FIFO_DEPTH)
   ) u_fifo (
      .clk   (axi4_aclk),
      .rst_n (axi4_arstn),
      .push  (drop_i),
      .pop   (pop),
      .din   (push_entry),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign drop_ready_o = !fifo_full;
   assign last_beat    = (cnt_q == head.len);
   assign unused_head  = ^{head.id, head.user};

   always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
      if (!axi4_arstn) begin
         state_q    <= FWD;
         in_burst_q <= 1'b0;
         cnt_q      <= '0;
         done_o     <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_burst_q <= in_burst_d;
         cnt_q      <= cnt_d;
         done_o     <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      in_burst_d    = in_burst_q;
      cnt_d         = cnt_q;
      done_d        = 1'b0;
      pop           = 1'b0;
      s_axi4_rid    = m_axi4_rid;
      s_axi4_rresp  = m_axi4_rresp;
      s_axi4_rdata  = m_axi4_rdata;
      s_axi4_rlast  = m_axi4_rlast;
      s_axi4_rvalid = m_axi4_rvalid;
      s_axi4_ruser  = m_axi4_ruser;
      m_axi4_rready = s_axi4_rready;
      unique case (state_q)
         FWD: begin
            if (!fifo_empty && !in_burst_q) begin
               // Bubble: block both sides for one cycle, then drop.
               s_axi4_rvalid = 1'b0;
               m_axi4_rready = 1'b0;
               state_d       = DROP;
               cnt_d         = '0;
            end else if (m_axi4_rvalid && s_axi4_rready) begin
               in_burst_d = !m_axi4_rlast;
            end
         end
         DROP: begin
            s_axi4_rvalid = 1'b1;
            s_axi4_rresp  = RRESP_SLVERR;
            s_axi4_rdata  = '0;
            s_axi4_rid    = head.id[AXI_ID_WIDTH-1:0];
            s_axi4_ruser  = head.user[AXI_USER_WIDTH-1:0];
            s_axi4_rlast  = last_beat;
            m_axi4_rready = 1'b0;
            if (s_axi4_rready) begin
               if (last_beat) begin
                  pop     = 1'b1;
                  done_d  = 1'b1;
                  state_d = FWD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: ;
      endcase
   end

endmodule
